axi_atop_r_inject_arb: RTL and testbench
========================================

# axi_atop_r_inject_arb

Arbiter that merges upstream AXI R traffic from two sources: R bursts returned by the downstream slave, and SLVERR R bursts injected locally for rejected atomic (ATOP) writes that expect a read response. It sits on the upstream R channel of the ATOP filtering path. It queues injection commands, never interleaves beats of different bursts, and alternates fairly between the two sources at burst granularity.

## Interface
- AXI_ID_WIDTH, 4: R/command ID width
- AXI_DATA_WIDTH, 64: R data width
- AXI_USER_WIDTH, 2: R user width
- INJ_DEPTH, 4: injection command FIFO depth (>=1)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- inj_valid_i  in  1  injection command valid
- inj_ready_o  out  1  command FIFO not full
- inj_id_i  in  AXI_ID_WIDTH  ID of rejected ATOP
- inj_len_i  in  8  AXI len of rejected ATOP (beats-1)
- dn_r_valid_i / dn_r_ready_o  in/out  1  downstream R handshake
- dn_r_id_i, dn_r_data_i, dn_r_resp_i(2), dn_r_last_i, dn_r_user_i  in  downstream R payload
- up_r_valid_o / up_r_ready_i  out/in  1  upstream R handshake
- up_r_id_o, up_r_data_o, up_r_resp_o(2), up_r_last_o, up_r_user_o  out  upstream R payload
- busy_o  out  1  burst in progress or FIFO non-empty

## Operation
- Command FIFO: push on inj_valid_i && inj_ready_o; inj_ready_o = !full; pop when last injected beat handshakes upstream. Push and pop in same cycle allowed when not full; count unchanged.
- State machine: IDLE, FWD (downstream burst locked), INJ (injected burst locked).
- IDLE: candidates = dn_r_valid_i, FIFO non-empty. One candidate -> grant it. Both -> grant per priority bit prio (0 = downstream first). Granted beat is presented upstream in same cycle.
- Transition from IDLE: to FWD/INJ on grant unless the granted beat handshakes with last=1 (then stay IDLE). Grant is thus locked whenever a valid is pending without ready (AXI valid stability).
- FWD: up_r_* = dn_r_*; dn_r_ready_o = up_r_ready_i; to IDLE on handshake with dn_r_last_i.
- INJ: up_r_valid_o = 1; id = FIFO head id; data = 0; user = 0; resp = 2'b10 (SLVERR); last = (beat_cnt == head len). beat_cnt (8 bit) increments per handshake, clears on last; to IDLE on last handshake.
- prio updates only on completed burst: set to 1 after downstream burst, 0 after injected burst (last-served loses).
- dn_r_ready_o = 0 whenever injected source is granted/locked; no payload passes through when not granted.
- busy_o = (state != IDLE) || FIFO non-empty.

## Timing
- Reset (async, rst_ni low): state IDLE, FIFO empty, beat_cnt 0, prio 0; up_r_valid_o 0, dn_r_ready_o 0, inj_ready_o 0, busy_o 0; up_r_* payload 0.
- After reset release: inj_ready_o 1 in first cycle.
- Downstream forward path: zero-cycle combinational latency, no bubbles within or between bursts.
- Injected command: earliest first beat the cycle after push (FIFO registered); len=N yields N+1 back-to-back beats if up_r_ready_i held high.
- Burst boundary switch: no idle cycle; next grant evaluated in the cycle after the last beat (IDLE).
- FIFO full: inj_ready_o 0 until a pop; command presented while full is held by requester, not dropped.
- len=255 injection: beat_cnt reaches 255 without overflow; last asserted on beat 256.
- Upstream backpressure: all outputs stable while up_r_valid_o && !up_r_ready_i.

## Test plan
- Reset mid-injection (rst_ni low during beat 2 of len=3 burst) -> up_r_valid_o 0 immediately, FIFO empty, after release no residual beats.
- Single inj id=5 len=3, up_r_ready_i=1 -> 4 beats id 5, data 0, resp 2'b10, last only on 4th, from cycle after push.
- Downstream 2-beat burst id=3 with inj id=7 len=0 pending simultaneously, prio=0 -> downstream beats first, then single SLVERR beat id 7; no interleave.
- Continuous downstream bursts plus 3 queued injections -> strict alternation downstream/injected per burst.
- Push 5 commands with INJ_DEPTH=4 and up_r_ready_i=0 -> inj_ready_o low after 4th, 5th accepted the cycle after first pop.
- Random up_r_ready_i stalls -> up_r_* never changes while valid && !ready; beat count per ID equals len+1.

Source files
------------

// File: rtl/axi_atop_r_inject_arb_if.sv
// AXI R channel bundle used on both sides of the ATOP R-injection arbiter.
// The master side drives the beat and the slave side returns ready.
interface axi_atop_r_inject_arb_if #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 2
);
    logic                      valid;
    logic                      ready;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
    logic [AXI_USER_WIDTH-1:0] user;

    modport master (output valid, id, data, resp, last, user, input ready);
    modport slave  (input valid, id, data, resp, last, user, output ready);
endinterface

// File: rtl/axi_atop_r_inject_arb.sv
// Merges downstream R bursts with locally injected SLVERR bursts for rejected ATOPs.
// Bursts are never interleaved; the two sources alternate at burst granularity.
module axi_atop_r_inject_arb #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 2,
    parameter int INJ_DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    inj_valid_i,
    output logic                    inj_ready_o,
    input  logic [AXI_ID_WIDTH-1:0] inj_id_i,
    input  logic [7:0]              inj_len_i,
    axi_atop_r_inject_arb_if.slave  dn_r,
    axi_atop_r_inject_arb_if.master up_r,
    output logic                    busy_o
);
    localparam int PTR_W = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
    localparam int CNT_W = $clog2(INJ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FWD, INJ} state_e;

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [AXI_ID_WIDTH-1:0] mem_id_q [INJ_DEPTH];
    logic [7:0]              mem_len_q [INJ_DEPTH];

    logic sel_dn, sel_inj, full, empty, push, pop, hs, done;
    logic [AXI_ID_WIDTH-1:0] head_id;
    logic [7:0]              head_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(INJ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(INJ_DEPTH));
    assign empty    = (count_q == '0);
    assign head_id  = mem_id_q[rd_ptr_q];
    assign head_len = mem_len_q[rd_ptr_q];

    // Grant: locked while a burst is open, otherwise alternate on prio when both compete.
    always_comb begin
        sel_dn  = 1'b0;
        sel_inj = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dn_r.valid && !empty) begin
                    sel_inj = prio_q;
                    sel_dn  = !prio_q;
                end else if (dn_r.valid) begin
                    sel_dn = 1'b1;
                end else if (!empty) begin
                    sel_inj = 1'b1;
                end
            end
            FWD:     sel_dn  = 1'b1;
            INJ:     sel_inj = 1'b1;
            default: ;
        endcase
        // Outputs must read idle/zero while reset is asserted, independent of inputs.
        if (!rst_ni) begin
            sel_dn  = 1'b0;
            sel_inj = 1'b0;
        end
    end

    always_comb begin
        up_r.valid = 1'b0;
        up_r.id    = '0;
        up_r.data  = '0;
        up_r.resp  = 2'b00;
        up_r.last  = 1'b0;
        up_r.user  = '0;
        dn_r.ready = 1'b0;
        if (sel_dn) begin
            up_r.valid = dn_r.valid;
            up_r.id    = dn_r.id;
            up_r.data  = dn_r.data;
            up_r.resp  = dn_r.resp;
            up_r.last  = dn_r.last;
            up_r.user  = dn_r.user;
            dn_r.ready = up_r.ready;
        end else if (sel_inj) begin
            up_r.valid = 1'b1;
            up_r.id    = head_id;
            up_r.resp  = 2'b10;
            up_r.last  = (beat_cnt_q == head_len);
        end
    end

    assign hs          = up_r.valid && up_r.ready;
    assign done        = hs && up_r.last;
    assign inj_ready_o = rst_ni && !full;
    assign push        = inj_valid_i && inj_ready_o;
    assign pop         = sel_inj && done;
    assign busy_o      = (state_q != IDLE) || !empty;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (sel_dn)  state_d = FWD;
        if (sel_inj) state_d = INJ;
        // A single-beat burst that completes on grant never leaves IDLE.
        if (done) begin
            state_d = IDLE;
            prio_d  = sel_dn;
        end
        if (sel_inj && hs) beat_cnt_d = up_r.last ? 8'd0 : beat_cnt_q + 8'd1;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            beat_cnt_q <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_id_q[wr_ptr_q]  <= inj_id_i;
            mem_len_q[wr_ptr_q] <= inj_len_i;
        end
    end
endmodule

// File: tb/tb_axi_atop_r_inject_arb.sv
// Randomised bench for axi_atop_r_inject_arb against a burst-level queue model.
module tb_axi_atop_r_inject_arb;
    localparam int ID_W = 4, DATA_W = 64, USER_W = 2, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             inj_valid, inj_ready, busy;
    logic [ID_W-1:0]  inj_id;
    logic [7:0]       inj_len;

    axi_atop_r_inject_arb_if #(.AXI_ID_WIDTH(ID_W), .AXI_DATA_WIDTH(DATA_W), .AXI_USER_WIDTH(USER_W)) dn_if ();
    axi_atop_r_inject_arb_if #(.AXI_ID_WIDTH(ID_W), .AXI_DATA_WIDTH(DATA_W), .AXI_USER_WIDTH(USER_W)) up_if ();

    axi_atop_r_inject_arb #(
        .AXI_ID_WIDTH(ID_W), .AXI_DATA_WIDTH(DATA_W), .AXI_USER_WIDTH(USER_W), .INJ_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .inj_valid_i(inj_valid), .inj_ready_o(inj_ready),
        .inj_id_i(inj_id), .inj_len_i(inj_len),
        .dn_r(dn_if.slave), .up_r(up_if.master),
        .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [ID_W-1:0] id; logic [7:0] len; } cmd_t;

    // Reference model: queued commands, owner of the open burst (0 none, 1 dn, 2 inj), fairness bit.
    cmd_t q[$];
    int   cur, beat, inj_obs;
    bit   prio;

    // Stimulus generator state.
    int p_new, p_dn, p_inj, p_rdy, max_len;
    bit dn_act, dn_hold, inj_pend;
    logic [ID_W-1:0] dn_bid, inj_pid;
    int   dn_blen, dn_beat;
    logic [7:0] inj_plen;

    task automatic model_reset();
        q.delete();
        cur = 0; beat = 0; inj_obs = 0; prio = 1'b0;
        dn_act = 1'b0; dn_hold = 1'b0; inj_pend = 1'b0;
    endtask

    task automatic knobs(input int nw, input int dv, input int ij, input int rd);
        p_new = nw; p_dn = dv; p_inj = ij; p_rdy = rd;
    endtask

    task automatic step();
        int src;
        bit ev, el, edr, hs, acc;
        logic [ID_W-1:0]   eid;
        logic [DATA_W-1:0] edata;
        logic [1:0]        eresp;
        logic [USER_W-1:0] euser;
        @(posedge clk);
        #1;
        if (!dn_hold) begin
            if (!dn_act && $urandom_range(99) < p_new) begin
                dn_act = 1'b1; dn_bid = ID_W'($urandom); dn_blen = $urandom_range(3); dn_beat = 0;
            end
            dn_if.valid = dn_act && ($urandom_range(99) < p_dn);
            dn_if.id    = dn_act ? dn_bid : ID_W'($urandom);
            dn_if.data  = {$urandom, $urandom};
            dn_if.resp  = 2'($urandom);
            dn_if.user  = USER_W'($urandom);
            dn_if.last  = dn_act ? (dn_beat == dn_blen) : 1'($urandom);
        end
        if (!inj_pend && $urandom_range(99) < p_inj) begin
            inj_pend = 1'b1; inj_pid = ID_W'($urandom); inj_plen = 8'($urandom_range(max_len));
        end
        inj_valid   = inj_pend;
        inj_id      = inj_pend ? inj_pid : ID_W'($urandom);
        inj_len     = inj_pend ? inj_plen : 8'($urandom);
        up_if.ready = ($urandom_range(99) < p_rdy);
        #1;
        src = cur;
        if (cur == 0) begin
            if (dn_if.valid && q.size() > 0) src = prio ? 2 : 1;
            else if (dn_if.valid)            src = 1;
            else if (q.size() > 0)           src = 2;
        end
        ev = 0; el = 0; edr = 0; eid = '0; edata = '0; eresp = 2'b00; euser = '0;
        if (src == 1) begin
            ev = dn_if.valid; eid = dn_if.id; edata = dn_if.data; eresp = dn_if.resp;
            el = dn_if.last; euser = dn_if.user; edr = up_if.ready;
        end else if (src == 2) begin
            ev = 1; eid = q[0].id; eresp = 2'b10; el = (beat == int'(q[0].len));
        end
        chk("up_valid", up_if.valid, ev);
        chk("up_id", up_if.id, eid);
        chk("up_data", up_if.data, edata);
        chk("up_resp", up_if.resp, eresp);
        chk("up_last", up_if.last, el);
        chk("up_user", up_if.user, euser);
        chk("dn_ready", dn_if.ready, edr);
        chk("inj_ready", inj_ready, q.size() < DEPTH);
        chk("busy", busy, (cur != 0) || (q.size() > 0));
        // Advance the model across the coming clock edge.
        hs  = ev && up_if.ready;
        acc = inj_pend && (q.size() < DEPTH);
        if (src == 2 && up_if.valid && up_if.ready) inj_obs++;
        if (dn_if.valid && edr) begin
            dn_hold = 1'b0;
            if (dn_beat == dn_blen) dn_act = 1'b0; else dn_beat++;
        end else begin
            dn_hold = dn_if.valid;
        end
        if (src == 2 && hs) begin
            if (el) begin
                chk("inj_beats", inj_obs, int'(q[0].len) + 1);
                inj_obs = 0; beat = 0;
                void'(q.pop_front());
            end else begin
                beat++;
            end
        end
        if (acc) begin
            q.push_back('{id: inj_pid, len: inj_plen});
            inj_pend = 1'b0;
        end
        if (hs && el) begin
            cur = 0; prio = (src == 1);
        end else begin
            cur = src;
        end
    endtask

    task automatic drain();
        knobs(0, 100, 0, 100);
        repeat (150) step();
    endtask

    initial begin
        int n;
        model_reset();
        max_len = 3;
        knobs(0, 0, 0, 0);
        inj_valid = 1'b0; inj_id = '0; inj_len = '0;
        up_if.ready = 1'b1;
        dn_if.valid = 1'b1; dn_if.id = 4'hA; dn_if.data = 64'hDEAD_BEEF_0123_4567;
        dn_if.resp = 2'b01; dn_if.last = 1'b1; dn_if.user = 2'b11;
        #12;
        chk("rst_up_valid", up_if.valid, 1'b0);
        chk("rst_up_data", up_if.data, 64'd0);
        chk("rst_up_id", up_if.id, 4'd0);
        chk("rst_dn_ready", dn_if.ready, 1'b0);
        chk("rst_inj_ready", inj_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        dn_if.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single injection id 5, len 3.
        inj_pend = 1'b1; inj_pid = 4'd5; inj_plen = 8'd3;
        knobs(0, 0, 0, 100);
        repeat (8) step();

        // Downstream 2-beat burst id 3 racing an injection id 7 len 0.
        dn_act = 1'b1; dn_bid = 4'd3; dn_blen = 1; dn_beat = 0;
        inj_pend = 1'b1; inj_pid = 4'd7; inj_plen = 8'd0;
        knobs(0, 100, 0, 100);
        repeat (6) step();

        // Continuous downstream traffic with queued injections.
        knobs(100, 100, 100, 100);
        repeat (60) step();
        drain();

        // Fill the command FIFO under full backpressure, then release.
        knobs(0, 0, 100, 0);
        repeat (10) step();
        knobs(0, 0, 0, 100);
        repeat (40) step();

        // Maximum-length injection.
        inj_pend = 1'b1; inj_pid = 4'd12; inj_plen = 8'd255;
        repeat (270) step();

        // Random mix with stalls.
        max_len = 6;
        knobs(30, 70, 20, 60);
        repeat (3000) step();
        drain();

        // Reset in the middle of an injected burst.
        inj_pend = 1'b1; inj_pid = 4'd9; inj_plen = 8'd3;
        knobs(0, 0, 0, 100);
        n = 0;
        while (!(cur == 2 && beat == 2) && n < 20) begin
            step();
            n++;
        end
        chk("reach_mid_burst", n < 20, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_up_valid", up_if.valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_inj_ready", inj_ready, 1'b0);
        chk("midrst_dn_ready", dn_if.ready, 1'b0);
        dn_if.valid = 1'b0;
        inj_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        knobs(0, 0, 0, 100);
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
